up_counter_tff: RTL and testbench
=================================

# up_counter_tff

Synchronous, cascadable, modulo-N up counter built from toggle flip-flops. It is the counting-up counterpart of the existing down counter and shares its T-flip-flop style. It provides synchronous load, count enable, carry-in/carry-out for chaining stages (e.g. BCD digits), a terminal-count flag and a sticky overflow flag. It sits beside the down counter in the counter/timer library and feeds display and timer logic.

## Interface
- WIDTH, 4, counter width in bits
- MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- en  input  1  count enable
- ci  input  1  carry-in from the previous stage; tie to 1 for the first stage
- load  input  1  synchronous load strobe
- d  input  WIDTH  load value
- clr_ovf  input  1  clears the sticky overflow flag
- q  output  WIDTH  current count
- tc  output  1  terminal count: q == MODULUS-1
- co  output  1  carry-out: en & ci & tc; combinational
- ovf  output  1  sticky flag; set on every wrap MODULUS-1 -> 0
- err  output  1  sticky flag; set when a load value is out of range

## Operation
- Reset values: q=0, ovf=0, err=0. tc=0 and co=0 during reset (except MODULUS=1, which is illegal).
- The count state is held in WIDTH T flip-flops. The next state is produced only through toggle enables t[i].
- Priority per cycle: load > count > hold.
- **Load** (load=1): the counter ignores en and ci.
  - If d < MODULUS: q <= d, using t = q ^ d.
  - If d >= MODULUS: q <= MODULUS-1 and err <= 1.
  - A load never sets ovf.
- **Count** (load=0, en=1, ci=1):
  - If q != MODULUS-1: q <= q+1, using t[i] = &q[i-1:0] (t[0]=1).
  - If q == MODULUS-1: q <= 0 (t = q) and ovf <= 1.
- **Hold**: in all other cases, t = 0 and q is unchanged.
- ovf clear: clr_ovf=1 clears ovf at the next edge. If a wrap occurs in the same cycle, the set wins and ovf stays 1.
- err is cleared only by rst.
- Cascading: stage k+1 takes ci = co of stage k, with the same en. The whole chain advances in a single clock with no ripple across edges.

## Timing
- The counter updates on the rising clk edge. q, tc and ovf are visible one cycle after the qualifying inputs are sampled.
- co is combinational from en, ci and q. Its path is one AND plus compare per stage, so the chain length is limited by the clock period.
- Asynchronous reset: asserting rst mid-count forces q=0, ovf=0 and err=0 immediately.
- Deassertion of rst must be synchronized externally. The first count occurs at the first edge after rst is low, if en & ci are high.
- There are no handshakes and no multi-cycle latency. Throughput is one increment per clock.

## Structure
- Shared package counter_pkg holds:
  - default WIDTH and MODULUS constants
  - a function next_toggle(q, mode, d) returning the t vector
  - a mode enum: HOLD, COUNT, WRAP, LOAD
- One sub-module t_ff is instantiated WIDTH times in a generate loop.
  - Ports: clk, rst, t, q.
  - Behaviour: asynchronous active-high reset to 0; q toggles when t=1.
- The top level contains:
  - mode decode
  - the toggle-vector generation
  - the ovf and err registers
  - the tc and co combinational logic

## Test plan
- Reset mid-count: WIDTH=4, MODULUS=16, en=ci=1, run to q=7, pulse rst for 3 ns off-edge -> q=0 and ovf=0 immediately; after release, count resumes 1, 2, 3.
- Wrap: MODULUS=10, en=ci=1 from 0 for 10 cycles -> q goes 0..9 and then 0; tc=1 and co=1 only while q=9; ovf goes to 1 after the wrap edge.
- Load priority and range: load=1 with d=5 while en=1 -> q=5, no increment, err=0; then load with d=12 (MODULUS=10) -> q=9, err=1.
- Overflow clear collision: clr_ovf=1 in the same cycle as a 9->0 wrap -> ovf stays 1; clr_ovf=1 on the next cycle -> ovf=0.
- Cascade: two MODULUS=10 stages, the low stage's co drives the high stage's ci, 100 enabled cycles from 00 -> sequence 00..99, then 00; the high stage's ovf is set once.
- Hold: en=0 or ci=0 for 5 cycles at q=3 -> q stays 3 and co=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer library: default sizes,
// the per-cycle mode enum and the toggle-vector helper used by T-FF counters.
package counter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 16;

    // Widest counter the toggle helper supports; callers zero-extend
    // into it and truncate the result back to their own width.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        HOLD,
        COUNT,
        WRAP,
        LOAD
    } mode_t;

    // Toggle enables that move q to its next value under the given mode.
    // d is the already range-clamped load target.
    function automatic logic [MAX_W-1:0] next_toggle(
        input logic [MAX_W-1:0] q,
        input mode_t            mode,
        input logic [MAX_W-1:0] d
    );
        logic [MAX_W-1:0] t;
        logic             c;
        t = '0;
        c = 1'b1;
        unique case (mode)
            LOAD: t = q ^ d;
            WRAP: t = q;
            COUNT: begin
                // bit i toggles when every lower bit is 1
                for (int i = 0; i < MAX_W; i++) begin
                    t[i] = c;
                    c    = c & q[i];
                end
            end
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/t_ff.sv
// Single toggle flip-flop with asynchronous active-high reset to 0.
// Ports: clk, rst, t (toggle enable), q (state).
module t_ff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/up_counter_tff.sv
// Cascadable modulo-MODULUS up counter built from T flip-flops.
// Ports: clk, rst, en, ci, load, d, clr_ovf in; q, tc, co, ovf, err out.
module up_counter_tff
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ci,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             co,
    output logic             ovf,
    output logic             err
);

    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic             in_range;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] t;
    mode_t            mode;

    // MODULUS may equal 2**WIDTH, so compare one bit wider
    assign in_range = ({1'b0, d} < MOD_EXT);
    assign load_val = in_range ? d : LAST;

    assign tc = (q == LAST);
    assign co = en & ci & tc;

    always_comb begin
        mode = HOLD;
        if (load) begin
            mode = LOAD;
        end else if (en && ci) begin
            mode = tc ? WRAP : COUNT;
        end
    end

    assign t = WIDTH'(next_toggle(MAX_W'(q), mode, MAX_W'(load_val)));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff u_tff (
            .clk(clk),
            .rst(rst),
            .t  (t[i]),
            .q  (q[i])
        );
    end

    // A wrap in the same cycle as clr_ovf keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (mode == WRAP) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (mode == LOAD && !in_range) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_up_counter_tff.sv
// Scoreboard bench for up_counter_tff: mod-10 unit, mod-10 cascade pair
// and mod-16 unit, checked against an arithmetic reference model.
module tb_up_counter_tff;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      en, ld, clr;
    logic [3:0]      tc, co, ovf, err;
    logic            ci0, ci3;
    logic [3:0][3:0] d;
    logic [3:0][3:0] q;

    always #10 clk = ~clk;

    up_counter_tff #(.WIDTH(4), .MODULUS(10)) u0 (
        .clk(clk), .rst(rst), .en(en[0]), .ci(ci0),
        .load(ld[0]), .d(d[0]), .clr_ovf(clr[0]),
        .q(q[0]), .tc(tc[0]), .co(co[0]),
        .ovf(ovf[0]), .err(err[0])
    );

    up_counter_tff #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rst(rst), .en(en[1]), .ci(1'b1),
        .load(ld[1]), .d(d[1]), .clr_ovf(clr[1]),
        .q(q[1]), .tc(tc[1]), .co(co[1]),
        .ovf(ovf[1]), .err(err[1])
    );

    up_counter_tff #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rst(rst), .en(en[2]), .ci(co[1]),
        .load(ld[2]), .d(d[2]), .clr_ovf(clr[2]),
        .q(q[2]), .tc(tc[2]), .co(co[2]),
        .ovf(ovf[2]), .err(err[2])
    );

    up_counter_tff #(.WIDTH(4), .MODULUS(16)) u3 (
        .clk(clk), .rst(rst), .en(en[3]), .ci(ci3),
        .load(ld[3]), .d(d[3]), .clr_ovf(clr[3]),
        .q(q[3]), .tc(tc[3]), .co(co[3]),
        .ovf(ovf[3]), .err(err[3])
    );

    typedef struct packed {
        logic [3:0][3:0] q;
        logic [3:0]      tc;
        logic [3:0]      co;
        logic [3:0]      ovf;
        logic [3:0]      err;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    int mods[4] = '{10, 10, 10, 16};
    int m_q[4];
    bit m_ovf[4];
    bit m_err[4];
    bit i_en[4], i_ci[4], i_ld[4], i_clr[4];
    int i_d[4];
    bit r_rst;

    function automatic void chk(string nm, int k, int got, int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d",
                     nm, k, $time, got, want);
        end
    endfunction

    // One clock of stimulus; the model computes what the DUTs
    // must show after the coming rising edge.
    task automatic cycle();
        exp_t e;
        bit   ci_a;
        @(negedge clk);
        i_en[2]  = i_en[1];
        i_ci[1]  = 1'b1;
        i_ld[1]  = 1'b0;
        i_ld[2]  = 1'b0;
        i_clr[2] = 1'b0;
        i_ci[2]  = i_en[1] && (m_q[1] == 9);
        rst = r_rst;
        ci0 = i_ci[0];
        ci3 = i_ci[3];
        for (int k = 0; k < 4; k++) begin
            en[k]  = i_en[k];
            ld[k]  = i_ld[k];
            clr[k] = i_clr[k];
            d[k]   = 4'(i_d[k]);
        end
        for (int k = 0; k < 4; k++) begin
            if (r_rst) begin
                m_q[k]   = 0;
                m_ovf[k] = 0;
                m_err[k] = 0;
            end else if (i_ld[k]) begin
                if (i_d[k] < mods[k]) begin
                    m_q[k] = i_d[k];
                end else begin
                    m_q[k]   = mods[k] - 1;
                    m_err[k] = 1;
                end
                if (i_clr[k]) m_ovf[k] = 0;
            end else if (i_en[k] && i_ci[k]) begin
                if (m_q[k] == mods[k] - 1) begin
                    m_q[k]   = 0;
                    m_ovf[k] = 1;
                end else begin
                    m_q[k] = m_q[k] + 1;
                    if (i_clr[k]) m_ovf[k] = 0;
                end
            end else if (i_clr[k]) begin
                m_ovf[k] = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            ci_a = (k == 2) ? (i_en[1] && m_q[1] == 9) : i_ci[k];
            e.q[k]   = 4'(m_q[k]);
            e.tc[k]  = (m_q[k] == mods[k] - 1);
            e.co[k]  = i_en[k] && ci_a && (m_q[k] == mods[k] - 1);
            e.ovf[k] = m_ovf[k];
            e.err[k] = m_err[k];
        end
        sb.push_back(e);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("async_rst_q", k, int'(q[k]), 0);
            chk("async_rst_ovf", k, int'(ovf[k]), 0);
        end
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_q[k]   = 0;
            m_ovf[k] = 0;
            m_err[k] = 0;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 4; k++) begin
                    chk("q", k, int'(q[k]), int'(e.q[k]));
                    chk("tc", k, int'(tc[k]), int'(e.tc[k]));
                    chk("co", k, int'(co[k]), int'(e.co[k]));
                    chk("ovf", k, int'(ovf[k]), int'(e.ovf[k]));
                    chk("err", k, int'(err[k]), int'(e.err[k]));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1;
        en  = '0;
        ld  = '0;
        clr = '0;
        d   = '0;
        ci0 = 1'b0;
        ci3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_q[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
            i_en[k] = 0; i_ci[k] = 1; i_ld[k] = 0;
            i_clr[k] = 0; i_d[k] = 0;
        end
        r_rst = 1'b1;
        repeat (3) cycle();
        r_rst = 1'b0;

        // mod-16: count to 7, async reset, resume 1,2,3
        i_en[3] = 1;
        repeat (7) cycle();
        mid_reset();
        repeat (3) cycle();

        // cascade runs from 00 for the rest of the directed part
        i_en[1] = 1;

        // mod-10 wrap 0..9 -> 0
        i_en[0] = 1;
        repeat (10) cycle();

        // clear colliding with wrap, then clear alone
        repeat (9) cycle();
        i_clr[0] = 1;
        cycle();
        i_en[0] = 0;
        cycle();
        i_clr[0] = 0;

        // load priority and range
        i_en[0] = 1;
        i_ld[0] = 1;
        i_d[0]  = 5;
        cycle();
        i_d[0] = 9;
        cycle();
        i_d[0] = 12;
        cycle();
        i_d[0] = 10;
        cycle();
        i_ld[3] = 1;
        i_d[3]  = 15;
        cycle();
        i_ld[3] = 0;

        // hold at 3 with en low, then ci low
        i_d[0] = 3;
        cycle();
        i_ld[0] = 0;
        i_en[0] = 0;
        repeat (3) cycle();
        i_en[0] = 1;
        i_ci[0] = 0;
        repeat (2) cycle();
        i_ci[0] = 1;

        // random traffic; cascade stays enabled past 100 counts first
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 4; k += 3) begin
                i_en[k]  = ($urandom_range(0, 3) != 0);
                i_ci[k]  = ($urandom_range(0, 3) != 0);
                i_ld[k]  = ($urandom_range(0, 7) == 0);
                i_clr[k] = ($urandom_range(0, 7) == 0);
                i_d[k]   = int'($urandom_range(0, 15));
            end
            if (n >= 90) i_en[1] = ($urandom_range(0, 3) != 0);
            cycle();
        end

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
